load_store_unit: RTL and testbench

- Memory-stage LSU, directly upstream of the data RAM.
- Accepts one load/store at a time from the execute stage and drives the RAM request bus (address, we, byte-enable code, write data, rd tag).
- Waits for grant/rvalid, then aligns and extends load data and returns it to writeback.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 67 ++++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, RV32 funct3 codes,
// RAM byte-enable codes and fault causes.
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitR,
      StResp
   } lsu_state_e;

   localparam logic [2:0] Funct3B  = 3'b000;
   localparam logic [2:0] Funct3H  = 3'b001;
   localparam logic [2:0] Funct3W  = 3'b010;
   localparam logic [2:0] Funct3Bu = 3'b100;
   localparam logic [2:0] Funct3Hu = 3'b101;

   localparam logic [3:0] BeWord  = 4'b0001;
   localparam logic [3:0] BeHalf0 = 4'b0010;
   localparam logic [3:0] BeHalf2 = 4'b0011;
   localparam logic [3:0] BeByte0 = 4'b1000;
   localparam logic [3:0] BeByte1 = 4'b1001;
   localparam logic [3:0] BeByte2 = 4'b1010;
   localparam logic [3:0] BeByte3 = 4'b1100;

   typedef enum logic [2:0] {
      FaultNone,
      FaultMisalign,
      FaultRange,
      FaultFunct3,
      FaultTimeout
   } fault_e;

   // Loads always fetch the full word; lane selection happens locally.
   function automatic logic [3:0] be_code(logic we, logic [2:0] f3, logic [1:0] lo);
      logic [3:0] be;
      be = BeWord;
      if (we) begin
         case (f3[1:0])
            2'b00: begin
               case (lo)
                  2'b00:   be = BeByte0;
                  2'b01:   be = BeByte1;
                  2'b10:   be = BeByte2;
                  default: be = BeByte3;
               endcase
            end
            2'b01:   be = lo[1] ? BeHalf2 : BeHalf0;
            default: be = BeWord;
         endcase
      end
      return be;
   endfunction

   function automatic fault_e check_fault(logic we, logic [2:0] f3, logic [31:0] addr,
                                          logic [31:0] limit);
      logic legal;
      legal = (f3 == Funct3B) || (f3 == Funct3H) || (f3 == Funct3W) ||
              (!we && ((f3 == Funct3Bu) || (f3 == Funct3Hu)));
      if (!legal) return FaultFunct3;
      if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00))
         return FaultMisalign;
      if (addr >= limit) return FaultRange;
      return FaultNone;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a little-endian RAM word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      case (funct3_i)
         Funct3B:  result_o = {{24{byte_sel[7]}}, byte_sel};
         Funct3H:  result_o = {{16{half_sel[15]}}, half_sel};
         Funct3Bu: result_o = {24'h0, byte_sel};
         Funct3Hu: result_o = {16'h0, half_sel};
         default:  result_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit driving the data RAM request bus. Optional macro
// LSU_TIMEOUT_EN aborts an access that waits TIMEOUT_CYCLES for gnt/rvalid.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT     = 32'h0000_7D00,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_funct3_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic [4:0]  lsu_rd_i,
   output logic        data_req_o,
   output logic [31:0] data_add_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   output logic [4:0]  data_rd_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   output logic        done_o,
   output logic        wb_we_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        fault_o
);

   lsu_state_e  state_q, state_d;
   fault_e      cause_q, cause_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic        accept, capture;
   logic [31:0] load_result, store_data;
   logic        in_req, in_resp, load_ok;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
   logic [CntW-1:0] tmo_cnt_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      accept  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (lsu_valid_i) begin
               accept  = 1'b1;
               cause_d = check_fault(lsu_we_i, lsu_funct3_i, lsu_addr_i, ADDR_LIMIT);
               state_d = (cause_d != FaultNone) ? StResp : StReq;
            end
         end
         StReq: begin
            if (data_gnt_i) begin
               if (we_q) begin
                  state_d = StResp;
               end else if (data_rvalid_i) begin
                  capture = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StWaitR;
               end
            end
         end
         StWaitR: begin
            if (data_rvalid_i) begin
               capture = 1'b1;
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
`ifdef LSU_TIMEOUT_EN
      // A grant or rvalid in the final allowed cycle still wins over the abort.
      if ((state_q == StReq || state_q == StWaitR) && state_d != StResp &&
          tmo_cnt_q == TmoLast) begin
         state_d = StResp;
         cause_d = FaultTimeout;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cause_q  <= FaultNone;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (accept) begin
            addr_q   <= lsu_addr_i;
            wdata_q  <= lsu_wdata_i;
            we_q     <= lsu_we_i;
            funct3_q <= lsu_funct3_i;
            rd_q     <= lsu_rd_i;
            rdata_q  <= '0;
         end
         if (capture) rdata_q <= data_rdata_i;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else if (accept) begin
         tmo_cnt_q <= '0;
      end else if (state_q == StReq || state_q == StWaitR) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`endif

   lsu_load_align u_load_align (
      .word_i    (rdata_q),
      .addr_lo_i (addr_q[1:0]),
      .funct3_i  (funct3_q),
      .result_o  (load_result)
   );

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   store_data = {4{wdata_q[7:0]}};
         2'b01:   store_data = {2{wdata_q[15:0]}};
         default: store_data = wdata_q;
      endcase
   end

   assign in_req  = (state_q == StReq);
   assign in_resp = (state_q == StResp);
   assign load_ok = in_resp && !we_q && (cause_q == FaultNone);

   assign lsu_ready_o  = (state_q == StIdle);
   assign data_req_o   = in_req;
   assign data_add_o   = in_req ? addr_q : '0;
   assign data_we_o    = in_req && we_q;
   assign data_be_o    = in_req ? be_code(we_q, funct3_q, addr_q[1:0]) : '0;
   assign data_wdata_o = (in_req && we_q) ? store_data : '0;
   assign data_rd_o    = in_req ? rd_q : '0;

   assign done_o    = in_resp;
   assign fault_o   = in_resp && (cause_q != FaultNone);
   assign wb_we_o   = load_ok && (rd_q != 5'd0);
   assign wb_rd_o   = in_resp ? rd_q : '0;
   assign wb_data_o = load_ok ? load_result : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: each op pushes its expected completion, and a
// negedge monitor pops and compares it when done_o fires.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_valid_i, lsu_ready_o, lsu_we_i;
   logic [2:0]  lsu_funct3_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic [4:0]  lsu_rd_i;
   logic        data_req_o, data_we_o;
   logic [31:0] data_add_o, data_wdata_o;
   logic [3:0]  data_be_o;
   logic [4:0]  data_rd_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        done_o, wb_we_o, fault_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;

   load_store_unit dut (
      .clk          (clk),
      .rst          (rst),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_ready_o  (lsu_ready_o),
      .lsu_we_i     (lsu_we_i),
      .lsu_funct3_i (lsu_funct3_i),
      .lsu_addr_i   (lsu_addr_i),
      .lsu_wdata_i  (lsu_wdata_i),
      .lsu_rd_i     (lsu_rd_i),
      .data_req_o   (data_req_o),
      .data_add_o   (data_add_o),
      .data_we_o    (data_we_o),
      .data_be_o    (data_be_o),
      .data_wdata_o (data_wdata_o),
      .data_rd_o    (data_rd_o),
      .data_gnt_i   (data_gnt_i),
      .data_rvalid_i(data_rvalid_i),
      .data_rdata_i (data_rdata_i),
      .done_o       (done_o),
      .wb_we_o      (wb_we_o),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .fault_o      (fault_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned done_cyc;
      logic        fault;
      logic        wb_we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done_o) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 32'(done_o), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_val("done_cycle", cyc, e.done_cyc);
            check_val("fault", 32'(fault_o), 32'(e.fault));
            check_val("wb_we", 32'(wb_we_o), 32'(e.wb_we));
            check_val("wb_data", wb_data_o, e.data);
            if (e.wb_we) check_val("wb_rd", 32'(wb_rd_o), 32'(e.rd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 12) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) begin
         check_val({name, "_no_done"}, 32'd0, 32'd1);
         sb_q.delete();
      end
   endtask

   task automatic run_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                         input logic exp_fault, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_res);
      exp_t e;
      int   lat;
      tick();
      check_val({name, "_ready"}, 32'(lsu_ready_o), 32'd1);
      lsu_valid_i  = 1'b1;
      lsu_we_i     = we;
      lsu_funct3_i = f3;
      lsu_addr_i   = addr;
      lsu_wdata_i  = wdata;
      lsu_rd_i     = rd;
      if (exp_fault) lat = 1;
      else if (we) lat = 2 + gnt_wait;
      else lat = 2 + gnt_wait + rv_wait;
      e.done_cyc = cyc + lat;
      e.fault    = exp_fault;
      e.wb_we    = !we && !exp_fault && (rd != 5'd0);
      e.rd       = rd;
      e.data     = (!we && !exp_fault) ? exp_res : 32'd0;
      sb_q.push_back(e);
      tick();
      lsu_valid_i = 1'b0;
      lsu_addr_i  = 32'hFFFF_FFFF;
      lsu_wdata_i = 32'h0BAD_0BAD;
      if (exp_fault) begin
         check_val({name, "_fault_noreq"}, 32'(data_req_o), 32'd0);
         tick();
         check_val({name, "_fault_noreq2"}, 32'(data_req_o), 32'd0);
      end else begin
         for (int i = 0; i <= gnt_wait; i++) begin
            check_val({name, "_req"}, 32'(data_req_o), 32'd1);
            check_val({name, "_add"}, data_add_o, addr);
            check_val({name, "_be"}, 32'(data_be_o), 32'(exp_be));
            check_val({name, "_we"}, 32'(data_we_o), 32'(we));
            check_val({name, "_rdtag"}, 32'(data_rd_o), 32'(rd));
            if (we) check_val({name, "_wdata"}, data_wdata_o, exp_wd);
            if (i == gnt_wait) begin
               data_gnt_i = 1'b1;
               if (!we && rv_wait == 0) begin
                  data_rvalid_i = 1'b1;
                  data_rdata_i  = rdata;
               end
            end
            tick();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_rdata_i  = 32'h5A5A_5A5A;
         end
         if (!we && rv_wait > 0) begin
            check_val({name, "_waitr_noreq"}, 32'(data_req_o), 32'd0);
            repeat (rv_wait - 1) tick();
            data_rvalid_i = 1'b1;
            data_rdata_i  = rdata;
            tick();
            data_rvalid_i = 1'b0;
            data_rdata_i  = 32'h5A5A_5A5A;
         end
      end
      drain(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      lsu_valid_i   = 1'b0;
      lsu_we_i      = 1'b0;
      lsu_funct3_i  = 3'b000;
      lsu_addr_i    = 32'h0;
      lsu_wdata_i   = 32'h0;
      lsu_rd_i      = 5'd0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h0;
      repeat (3) tick();
      check_val("rst_ready", 32'(lsu_ready_o), 32'd1);
      check_val("rst_req", 32'(data_req_o), 32'd0);
      check_val("rst_done", 32'(done_o), 32'd0);
      rst = 1'b0;

      //     name    we    f3        addr           wdata          rd     rdata        gw rw flt be       wd             res
      run_op("sw",   1'b1, Funct3W,  32'h0000_0010, 32'hDEAD_BEEF, 5'd3,  32'h0,       0, 0, 0, BeWord,  32'hDEAD_BEEF, 32'h0);
      run_op("lb",   1'b0, Funct3B,  32'h0000_0013, 32'h0,         5'd5,  32'h80FF_0000, 0, 0, 0, BeWord, 32'h0,       32'hFFFF_FF80);
      run_op("lhu",  1'b0, Funct3Hu, 32'h0000_0012, 32'h0,         5'd6,  32'h80FF_1234, 0, 3, 0, BeWord, 32'h0,       32'h0000_80FF);
      run_op("lw_mis", 1'b0, Funct3W, 32'h0000_0006, 32'h0,        5'd7,  32'h0,       0, 0, 1, BeWord,  32'h0,         32'h0);
      run_op("sh_oor", 1'b1, Funct3H, 32'h0000_7D00, 32'h1234,     5'd0,  32'h0,       0, 0, 1, BeWord,  32'h0,         32'h0);
      run_op("sb1",  1'b1, Funct3B,  32'h0000_0011, 32'h1234_56AB, 5'd0,  32'h0,       2, 0, 0, BeByte1, 32'hABAB_ABAB, 32'h0);
      run_op("sb2",  1'b1, Funct3B,  32'h0000_0012, 32'h0000_0077, 5'd0,  32'h0,       0, 0, 0, BeByte2, 32'h7777_7777, 32'h0);
      run_op("sb3",  1'b1, Funct3B,  32'h0000_0013, 32'h0000_00C1, 5'd0,  32'h0,       1, 0, 0, BeByte3, 32'hC1C1_C1C1, 32'h0);
      run_op("sh2",  1'b1, Funct3H,  32'h0000_0012, 32'hFFFF_5678, 5'd0,  32'h0,       0, 0, 0, BeHalf2, 32'h5678_5678, 32'h0);
      run_op("sh0",  1'b1, Funct3H,  32'h0000_0020, 32'h0000_9ABC, 5'd0,  32'h0,       0, 0, 0, BeHalf0, 32'h9ABC_9ABC, 32'h0);
      run_op("lh",   1'b0, Funct3H,  32'h0000_0000, 32'h0,         5'd9,  32'h1234_8001, 1, 2, 0, BeWord, 32'h0,       32'hFFFF_8001);
      run_op("lbu",  1'b0, Funct3Bu, 32'h0000_7CFF, 32'h0,         5'd10, 32'hC300_0000, 0, 0, 0, BeWord, 32'h0,       32'h0000_00C3);
      run_op("lw_x0", 1'b0, Funct3W, 32'h0000_7CFC, 32'h0,         5'd0,  32'hCAFE_F00D, 0, 1, 0, BeWord, 32'h0,       32'hCAFE_F00D);
      run_op("ld_f3", 1'b0, 3'b011,  32'h0000_0040, 32'h0,         5'd4,  32'h0,       0, 0, 1, BeWord,  32'h0,         32'h0);
      run_op("st_f3", 1'b1, Funct3Bu, 32'h0000_0040, 32'h0,        5'd0,  32'h0,       0, 0, 1, BeWord,  32'h0,         32'h0);

      // Reset while waiting for rvalid: the op is dropped and late rvalid ignored.
      tick();
      lsu_valid_i  = 1'b1;
      lsu_we_i     = 1'b0;
      lsu_funct3_i = Funct3W;
      lsu_addr_i   = 32'h0000_0020;
      lsu_rd_i     = 5'd7;
      tick();
      lsu_valid_i = 1'b0;
      check_val("rstw_req", 32'(data_req_o), 32'd1);
      data_gnt_i = 1'b1;
      tick();
      data_gnt_i = 1'b0;
      check_val("rstw_waitr", 32'(data_req_o), 32'd0);
      #2 rst = 1'b1;
      #1;
      check_val("rstw_ready", 32'(lsu_ready_o), 32'd1);
      check_val("rstw_done", 32'(done_o), 32'd0);
      check_val("rstw_wbdata", wb_data_o, 32'd0);
      check_val("rstw_wbwe", 32'(wb_we_o), 32'd0);
      check_val("rstw_add", data_add_o, 32'd0);
      tick();
      rst           = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h1111_2222;
      tick();
      data_rvalid_i = 1'b0;
      tick();
      check_val("rstw_late_done", 32'(done_o), 32'd0);
      check_val("rstw_idle", 32'(lsu_ready_o), 32'd1);
      run_op("post_rst", 1'b0, Funct3H, 32'h0000_0022, 32'h0, 5'd12, 32'h7FFF_0000, 0, 0, 0, BeWord,
             32'h0, 32'h0000_7FFF);

`ifdef LSU_TIMEOUT_EN
      begin : timeout_test
         exp_t e;
         tick();
         lsu_valid_i  = 1'b1;
         lsu_we_i     = 1'b0;
         lsu_funct3_i = Funct3W;
         lsu_addr_i   = 32'h0000_0040;
         lsu_rd_i     = 5'd8;
         e.done_cyc   = cyc + 17;
         e.fault      = 1'b1;
         e.wb_we      = 1'b0;
         e.rd         = 5'd8;
         e.data       = 32'd0;
         sb_q.push_back(e);
         tick();
         lsu_valid_i = 1'b0;
         repeat (18) tick();
         check_val("tmo_req_low", 32'(data_req_o), 32'd0);
         data_gnt_i    = 1'b1;
         data_rvalid_i = 1'b1;
         tick();
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         drain("tmo");
      end
`endif

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
